rr_byte_arbiter: RTL
====================

RR_BYTE_ARBITER -- requirements
Module: rr_byte_arbiter

Interface
REQ-001 Parameter: BURST_MAX, default 4, is the maximum number of bytes a requester may transfer per grant (legal range 1..15).
REQ-002 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous, active-high reset.
REQ-004 Ports: in_data0..in_data3, input, 8 each, requester byte data.
REQ-005 Ports: in_valid0..in_valid3, input, 1 each, requester has a byte available.
REQ-006 Ports: in_ready0..in_ready3, output, 1 each, combinational accept strobe per requester.
REQ-007 Port: out_ready, input, 1, downstream accepts data_out this cycle.
REQ-008 Port: data_out, output, 8, registered arbitrated byte.
REQ-009 Port: out_valid, output, 1, registered, data_out is valid.
REQ-010 Port: grant, output, 2, index of the currently or last granted requester.
REQ-011 Port: busy, output, 1, high while the FSM is in GRANT.

Function
REQ-012 FSM states SHALL be IDLE and GRANT only.
REQ-013 In IDLE with any in_validN=1, the next state SHALL be GRANT and grant SHALL load the first valid requester scanning last+1, last+2, ... modulo 4; with no in_valid set, stay in IDLE.
REQ-014 In_readyN SHALL be 1 only when state=GRANT, grant=N, and (out_valid=0 or out_ready=1); all other in_ready SHALL be 0.
REQ-015 A transfer SHALL occur when in_validN and in_readyN are both 1; next cycle data_out=in_dataN and out_valid=1 (1-cycle latency).
REQ-016 When out_valid=1 and out_ready=1 with no transfer in that cycle, out_valid SHALL clear next cycle; data_out SHALL hold its value.
REQ-017 When out_valid=1 and out_ready=0, data_out and out_valid SHALL hold and no in_ready SHALL assert.
REQ-018 A 4-bit burst counter SHALL clear on entry to GRANT and increment on each transfer.
REQ-019 GRANT SHALL return to IDLE when the granted in_valid is 0, or when a transfer occurs with counter = BURST_MAX-1; last SHALL then be set to grant.
REQ-020 Each grant change SHALL cost exactly one IDLE cycle; peak throughput is BURST_MAX bytes per BURST_MAX+1 cycles.
REQ-021 Non-granted requesters' in_valid changes SHALL NOT affect the current grant.
REQ-022 With BURST_MAX=1, every transfer SHALL end the grant.

Reset
REQ-023 On reset=1, asynchronously: state=IDLE, grant=0, last=3, counter=0, out_valid=0, data_out=8'h00, busy=0.
REQ-024 Reset asserted mid-burst SHALL discard the pending output byte; first post-reset grant SHALL go to requester 0 if valid.

Configuration
REQ-025 Macro ARB_PRIO_EN: when defined, in IDLE with in_valid0=1, requester 0 SHALL be granted regardless of last; otherwise round-robin per REQ-013.
REQ-026 Without ARB_PRIO_EN, requester 0 SHALL have no priority beyond its round-robin slot; last updates identically in both builds.

Verification
REQ-027 Reset, all in_valid=1, out_ready=1, BURST_MAX=4 -> grants 0,1,2,3,0 in order, 4 bytes each, one idle cycle between bursts.
REQ-028 Only in_valid2=1 with in_data2=8'hA5, out_ready=1 -> grant=2 after 1 cycle, data_out=8'hA5 with out_valid=1 one cycle after in_ready2.
REQ-029 In GRANT to 1, hold out_ready=0 for 3 cycles -> in_ready1=0, data_out and out_valid stable; on out_ready=1 transfers resume, no byte lost or duplicated.
REQ-030 Requester 3 granted, in_valid3 drops after 2 bytes -> IDLE next cycle, next grant to requester 0 if valid.
REQ-031 ARB_PRIO_EN defined, last=0, in_valid0=in_valid1=1 -> grant=0 (without macro grant=1).
REQ-032 Reset asserted mid-burst with out_valid=1 -> out_valid=0, data_out=8'h00 immediately, busy=0.

Source files
------------

// File: rtl/rr_byte_arbiter.sv
// ============================================================================
// rr_byte_arbiter
//
// Four-requester round-robin arbiter that moves single bytes from the granted
// requester into a one-entry registered output stage. A requester holds the
// grant for up to BURST_MAX bytes. The grant also ends when the requester
// drops in_valid. Each change of grant passes through one IDLE cycle.
//
// Parameters
//   BURST_MAX   maximum bytes per grant (legal range 1..15)
//
// Build option
//   ARB_PRIO_EN when defined, requester 0 wins any IDLE arbitration in which
//               it is valid. Otherwise arbitration is pure round-robin.
//
// Ports
//   clk                   single clock, rising edge
//   reset                 asynchronous, active-high reset
//   in_data0..3  [7:0]    requester byte data
//   in_valid0..3          requester has a byte available
//   in_ready0..3          combinational accept strobe per requester
//   out_ready             downstream accepts data_out this cycle
//   data_out     [7:0]    registered arbitrated byte
//   out_valid             registered, data_out is valid
//   grant        [1:0]    index of the current or most recent grant
//   busy                  high while a grant is active (GRANT state)
// ============================================================================
module rr_byte_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    input  logic [7:0] in_data2,
    input  logic [7:0] in_data3,
    input  logic       in_valid0,
    input  logic       in_valid1,
    input  logic       in_valid2,
    input  logic       in_valid3,
    output logic       in_ready0,
    output logic       in_ready1,
    output logic       in_ready2,
    output logic       in_ready3,
    input  logic       out_ready,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] last;        // requester that held the most recent grant
    logic [3:0] counter;     // bytes moved in the current grant

    logic [3:0] valid_vec;
    logic [7:0] data_vec [4];
    logic [3:0] ready_vec;
    logic [1:0] pick;

    logic       can_accept;
    logic       granted_valid;
    logic       xfer;
    logic       burst_done;

    assign valid_vec   = {in_valid3, in_valid2, in_valid1, in_valid0};
    assign data_vec[0] = in_data0;
    assign data_vec[1] = in_data1;
    assign data_vec[2] = in_data2;
    assign data_vec[3] = in_data3;

    assign in_ready0 = ready_vec[0];
    assign in_ready1 = ready_vec[1];
    assign in_ready2 = ready_vec[2];
    assign in_ready3 = ready_vec[3];

    // The output stage can take a new byte when it is empty or draining now.
    assign can_accept    = !out_valid || out_ready;
    assign granted_valid = valid_vec[grant];
    assign xfer          = (state == GRANT) && granted_valid && can_accept;
    assign burst_done    = xfer && (counter == 4'(BURST_MAX - 1));

    // Arbitration winner. Candidates are scanned from farthest to nearest
    // after 'last', so the nearest valid one is written last and wins.
    // Offset 4 wraps to 'last' itself, which is the lowest-priority slot.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves it unassigned infers a latch.
        pick = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (valid_vec[last + 2'(k)]) begin
                pick = last + 2'(k);
            end
        end
`ifdef ARB_PRIO_EN
        if (valid_vec[0]) begin
            pick = 2'd0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is always written with non-blocking
        // assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|valid_vec) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!granted_valid || burst_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state == GRANT);
        ready_vec = 4'b0000;
        if ((state == GRANT) && can_accept) begin
            ready_vec[grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping: grant index, round-robin pointer, burst counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant   <= 2'd0;
            last    <= 2'd3;   // so the first grant after reset scans from 0
            counter <= 4'd0;
        end else begin
            if ((state == IDLE) && (|valid_vec)) begin
                grant   <= pick;
                counter <= 4'd0;
            end else if (xfer) begin
                counter <= counter + 4'd1;
            end

            if ((state == GRANT) && (state_nxt == IDLE)) begin
                last <= grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: one registered byte, held while the consumer stalls
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: data_out is reset too, not only out_valid, because its
        // post-reset value is observable and must read 8'h00.
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= 8'h00;
        end else if (xfer) begin
            out_valid <= 1'b1;
            data_out  <= data_vec[grant];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
